// File: rtl/arb_pkg.sv
// Shared types and helpers for the 8-way round-robin grant arbiter.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } arb_state_t;

  // Result of a circular search: whether anyone is requesting, and who wins.
  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set bit of req, searching ptr, ptr+1, ..., wrapping through 0.
  // The loop runs from the farthest offset down so the nearest one is written last.
  function automatic pick_t rr_first(input logic [N_REQ-1:0] req,
                                     input logic [IDX_W-1:0] ptr);
    pick_t            result;
    logic [IDX_W-1:0] cand;
    result = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (req[cand]) begin
        result.found = 1'b1;
        result.idx   = cand;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/idx_decoder_3to8.sv
// Plain 3-to-8 one-hot decoder; the caller applies any valid masking.
module idx_decoder_3to8
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  // Exactly one output bit is set for every index value.
  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// 8-way round-robin arbiter with bounded hold and a one-cycle gap between owners.
// All outputs come from registers; gnt is the decoded grant index gated by gnt_valid.
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HCNT_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             busy
);

  // With the limit disabled the counter simply saturates at all-ones and is ignored.
  localparam logic [HCNT_W-1:0] HOLD_SAT =
    (MAX_HOLD == 0) ? {HCNT_W{1'b1}} : HCNT_W'(MAX_HOLD - 1);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [HCNT_W-1:0] hold_cnt, hold_nxt;
  logic [IDX_W-1:0] gnt_idx_nxt;
  logic             gnt_valid_nxt;
  logic             busy_nxt;

  logic [N_REQ-1:0] owner_onehot;
  pick_t            pick;
  logic             owner_req;
  logic             others_req;
  logic             hold_expired;
  logic             leave_grant;

  idx_decoder_3to8 u_decoder (
    .idx    (gnt_idx),
    .onehot (owner_onehot)
  );

  // Arbitration and exit conditions, all derived from the current request vector.
  always_comb begin
    pick         = rr_first(req, ptr);
    owner_req    = |(req & owner_onehot);
    others_req   = |(req & ~owner_onehot);
    hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_SAT);
    leave_grant  = !owner_req || (hold_expired && others_req);
  end

  // State register; reset drops any grant in progress immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection: GAP always lasts a single cycle before re-arbitrating.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pick.found) state_nxt = GRANT;
      GRANT:   if (leave_grant) state_nxt = GAP;
      GAP:     state_nxt = pick.found ? GRANT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the grant registers, pointer and hold counter.
  always_comb begin
    ptr_nxt       = ptr;
    hold_nxt      = hold_cnt;
    gnt_idx_nxt   = gnt_idx;
    gnt_valid_nxt = gnt_valid;
    busy_nxt      = (state_nxt != IDLE);
    unique case (state)
      IDLE, GAP: begin
        if (pick.found) begin
          gnt_idx_nxt   = pick.idx;
          gnt_valid_nxt = 1'b1;
          hold_nxt      = '0;
        end else begin
          gnt_valid_nxt = 1'b0;
        end
      end
      GRANT: begin
        if (leave_grant) begin
          gnt_valid_nxt = 1'b0;
          ptr_nxt       = gnt_idx + IDX_W'(1);
          hold_nxt      = '0;
        end else if (hold_cnt != HOLD_SAT) begin
          hold_nxt = hold_cnt + HCNT_W'(1);
        end
      end
      default: begin
        gnt_valid_nxt = 1'b0;
      end
    endcase
  end

  // Grant-side registers, cleared asynchronously together with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_nxt;
      gnt_idx   <= gnt_idx_nxt;
      gnt_valid <= gnt_valid_nxt;
      busy      <= busy_nxt;
    end
  end

  // Masking with gnt_valid keeps gnt all-zero while gnt_idx holds its last value.
  always_comb begin
    gnt = owner_onehot & {N_REQ{gnt_valid}};
  end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Self-checking bench for rr_grant_arbiter: directed scenarios followed by random traffic,
// every cycle compared against an owner/ptr level model of round-robin with hold limit.
module tb_rr_grant_arbiter;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       busy;

  int n_compared = 0;
  int n_failed   = 0;

  // Reference model: who owns the resource, for how many cycles, where the search starts
  int m_owner;
  int m_run;
  int m_start;
  int m_last;
  bit m_gap;

  rr_grant_arbiter #(
    .MAX_HOLD (MAXH),
    .HCNT_W   (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic int rr_pick(input logic [7:0] r, input int start);
    for (int off = 0; off < 8; off++) begin
      if (r[(start + off) % 8]) return (start + off) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_run   = 0;
    m_start = 0;
    m_last  = 0;
    m_gap   = 1'b0;
  endtask

  task automatic model_update(input logic [7:0] r);
    logic [7:0] others;
    int         w;
    if (m_owner >= 0) begin
      others          = r;
      others[m_owner] = 1'b0;
      if (!r[m_owner] || (m_run >= MAXH && others != 8'h00)) begin
        m_start = (m_owner + 1) % 8;
        m_owner = -1;
        m_gap   = 1'b1;
      end else begin
        m_run++;
      end
    end else begin
      w     = rr_pick(r, m_start);
      m_gap = 1'b0;
      if (w >= 0) begin
        m_owner = w;
        m_last  = w;
        m_run   = 1;
      end
    end
  endtask

  task automatic check_value(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_compared++;
    assert (obs === exp)
    else begin
      n_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag);
    logic [7:0] exp_gnt;
    exp_gnt = 8'h00;
    if (m_owner >= 0) exp_gnt[m_owner] = 1'b1;
    check_value({tag, "/gnt"}, gnt, exp_gnt);
    check_value({tag, "/gnt_idx"}, {5'd0, gnt_idx}, 8'(m_last));
    check_value({tag, "/gnt_valid"}, {7'd0, gnt_valid}, {7'd0, (m_owner >= 0)});
    check_value({tag, "/busy"}, {7'd0, busy}, {7'd0, (m_owner >= 0) || m_gap});
  endtask

  // Drive req away from the edge, let one rising edge pass, then compare on the falling edge.
  task automatic apply_stimulus(input logic [7:0] r, input string tag);
    req = r;
    @(posedge clk);
    model_update(r);
    @(negedge clk);
    check_output(tag);
  endtask

  // Entered and left on a falling edge; requests stay asserted throughout.
  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'hFF;
    model_reset();
    #1;
    check_output("reset");
    repeat (2) @(negedge clk);
    check_output("reset_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] preempt_seq [11];
    logic [7:0] r;
    logic [7:0] prev_r;
    int         kind;

    preempt_seq = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00,
                    8'h20, 8'h20, 8'h20, 8'h20, 8'h00, 8'h01};

    rst_n = 1'b0;
    req   = 8'hFF;
    model_reset();
    @(negedge clk);
    do_reset();

    $display("[TB] first grant after reset and single requester");
    apply_stimulus(8'hFF, "first");
    check_value("first_gnt", gnt, 8'h01);
    apply_stimulus(8'h00, "rel_gap");
    check_value("rel_gap_busy", {7'd0, busy}, 8'h01);
    apply_stimulus(8'h00, "rel_idle");
    apply_stimulus(8'h08, "single");
    check_value("single_gnt", gnt, 8'h08);
    check_value("single_idx", {5'd0, gnt_idx}, 8'd3);
    apply_stimulus(8'h08, "single_hold");
    apply_stimulus(8'h00, "single_gap");
    check_value("single_gap_gnt", gnt, 8'h00);
    check_value("single_gap_busy", {7'd0, busy}, 8'h01);
    apply_stimulus(8'h00, "single_idle");
    check_value("single_idle_busy", {7'd0, busy}, 8'h00);
    check_value("single_idle_idx", {5'd0, gnt_idx}, 8'd3);

    $display("[TB] round-robin order with wrap");
    @(negedge clk);
    do_reset();
    for (int k = 0; k <= 8; k++) begin
      apply_stimulus(8'hFF, $sformatf("rr%0d", k));
      check_value($sformatf("rr%0d_gnt", k), gnt, 8'(1 << (k % 8)));
      apply_stimulus(8'hFF & ~8'(1 << (k % 8)), $sformatf("rr%0d_gap", k));
      check_value($sformatf("rr%0d_gap_gnt", k), gnt, 8'h00);
    end

    $display("[TB] hold limit preemption");
    @(negedge clk);
    do_reset();
    for (int k = 0; k < 11; k++) begin
      apply_stimulus(8'h21, $sformatf("pre%0d", k));
      check_value($sformatf("pre%0d_gnt", k), gnt, preempt_seq[k]);
    end

    $display("[TB] lone requester keeps the grant");
    apply_stimulus(8'h40, "lone_gap");
    for (int k = 0; k < 20; k++) begin
      apply_stimulus(8'h40, $sformatf("lone%0d", k));
      check_value($sformatf("lone%0d_gnt", k), gnt, 8'h40);
    end
    check_value("lone_hold_sat", {3'd0, dut.hold_cnt}, 8'd3);

    $display("[TB] asynchronous reset in the middle of a grant");
    apply_stimulus(8'h10, "mid_gap");
    apply_stimulus(8'h10, "mid_grant");
    check_value("mid_grant_gnt", gnt, 8'h10);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_value("mid_async_gnt", gnt, 8'h00);
    check_output("mid_async");
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(8'h11, "mid_after");
    check_value("mid_after_gnt", gnt, 8'h01);

    $display("[TB] random traffic");
    prev_r = 8'h11;
    for (int c = 0; c < 600; c++) begin
      kind = int'($urandom_range(0, 9));
      if (kind < 4)       r = prev_r;
      else if (kind == 4) r = 8'h00;
      else if (kind < 7)  r = 8'(1 << $urandom_range(0, 7));
      else                r = 8'($urandom);
      prev_r = r;
      if ($urandom_range(0, 149) == 0) begin
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_output($sformatf("rnd_rst%0d", c));
        @(negedge clk);
        rst_n = 1'b1;
      end
      apply_stimulus(r, $sformatf("rnd%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
